// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: FSM states, read-source select,
// I/O window offsets and cpu bus direction constants.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Which source drives rdata in the cycle after a read was sampled.
  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_RAM  = 2'd1,
    RSEL_IO   = 2'd2
  } rsel_e;

  localparam logic [3:0] OUT_OFS    = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_ram.sv
// Single-port 32-bit synchronous RAM with registered read data.
// Contents are deliberately not reset so a loaded image survives a reset.
module mem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Write on enable; the read of the same index returns the old word, and a
  // read one cycle after a write sees the new word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the cpu bus: program/data RAM, a small I/O
// window, and a boot loader that fills RAM from a byte stream while the cpu
// is held in reset.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        rw,
  output logic [31:0] rdata,
  output logic        cpu_reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [31:0] out_data,
  output logic        out_strobe
);

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         out_data_q, out_data_d;
  logic                strobe_q, strobe_d;
  rsel_e               rsel_q, rsel_d;
  logic [31:0]         io_q, io_d;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_idx;
  logic [31:0]         ram_wd;
  logic [31:0]         ram_rd;
  logic                load_wr;
  logic                is_ram;
  logic                is_io;

  assign is_ram = (address[31:ADDR_W] == '0);
  assign is_io  = (address[31:4] == IO_BASE[31:4]);

  mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (ram_idx),
    .wdata_i (ram_wd),
    .rdata_o (ram_rd)
  );

  // Control and I/O registers; only these see the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      asm_q      <= '0;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      strobe_q   <= 1'b0;
      rsel_q     <= RSEL_NONE;
      io_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      strobe_q   <= strobe_d;
      rsel_q     <= rsel_d;
      io_q       <= io_d;
    end
  end

  // Next state, loader assembly, RAM port mux between loader and cpu, I/O.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    ptr_d      = ptr_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    strobe_d   = 1'b0;
    rsel_d     = RSEL_NONE;
    io_d       = '0;
    ram_we     = 1'b0;
    ram_idx    = address[ADDR_W-1:0];
    ram_wd     = wdata;
    load_wr    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
          if (idx_q == 2'd3) begin
            // Fourth byte completes the word: write it straight through.
            ram_we  = 1'b1;
            ram_idx = ptr_q;
            ram_wd  = {ld_byte, asm_q};
            load_wr = 1'b1;
            asm_d   = '0;
            idx_d   = 2'd0;
            if (ld_last) begin
              state_d = ST_RUN;
            end
          end else begin
            case (idx_q)
              2'd0:    asm_d[7:0]   = ld_byte;
              2'd1:    asm_d[15:8]  = ld_byte;
              default: asm_d[23:16] = ld_byte;
            endcase
            idx_d = idx_q + 2'd1;
            if (ld_last) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        // Partial final word; unfilled upper lanes are already zero.
        ram_we  = 1'b1;
        ram_idx = ptr_q;
        ram_wd  = {8'h00, asm_q};
        load_wr = 1'b1;
        asm_d   = '0;
        idx_d   = 2'd0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (rw == RW_READ) begin
          if (is_ram) begin
            rsel_d = RSEL_RAM;
          end else if (is_io) begin
            rsel_d = RSEL_IO;
            if (address[3:0] == STATUS_OFS) begin
              io_d = {30'b0, ovf_q, 1'b1};
            end
          end
        end else if (rw == RW_WRITE) begin
          if (is_ram) begin
            ram_we = 1'b1;
          end else if (is_io && (address[3:0] == OUT_OFS)) begin
            out_data_d = wdata;
            strobe_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    if (load_wr) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == '1) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Read data mux: selected by the source registered alongside the RAM read.
  always_comb begin
    rdata = '0;
    case (rsel_q)
      RSEL_RAM: rdata = ram_rd;
      RSEL_IO:  rdata = io_q;
      default:  rdata = '0;
    endcase
  end

  assign cpu_reset  = (state_q != ST_RUN);
  assign ld_ready   = (state_q == ST_LOAD);
  assign out_data   = out_data_q;
  assign out_strobe = strobe_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// loader images and bus traffic, checked against a behavioural memory model.
module tb_mem_responder;

  localparam int          ADDR_W  = 10;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        rw;
  logic [31:0] rdata;
  logic        cpu_reset;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic [31:0] out_data;
  logic        out_strobe;

  mem_responder #(.ADDR_W(ADDR_W), .IO_BASE(IO_BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .wdata      (wdata),
    .rw         (rw),
    .rdata      (rdata),
    .cpu_reset  (cpu_reset),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .out_data   (out_data),
    .out_strobe (out_strobe)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  bit          ref_ovf;
  logic [31:0] ref_out;
  logic [7:0]  img [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected read value from the address map rules.
  task automatic exp_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v     = '0;
    if (a < DEPTH) begin
      v     = ref_mem[a];
      known = ref_known[a];
    end else if ((a >> 4) == (IO_BASE >> 4)) begin
      if ((a & 32'hF) == 32'h4) v = {30'b0, ref_ovf, 1'b1};
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int c = 0; c < cycles; c++) begin
      chk("rst_cpu_reset", cpu_reset, 32'd1);
      chk("rst_ld_ready", ld_ready, 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_strobe", out_strobe, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      step();
    end
    reset   = 1'b1;
    ref_ovf = 1'b0;
    ref_out = '0;
  endtask

  // Bus activity that must be ignored while loading.
  task automatic bus_noise(input int i);
    rw      = i[0];
    address = i[0] ? 32'd0 : (i[1] ? IO_BASE : 32'd1);
    wdata   = $urandom;
  endtask

  // Drive img[] into the loader; with_last marks the final byte.
  task automatic load_image(input bit with_last);
    int n;
    int nw;
    logic [31:0] w;
    n = img.size();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        bus_noise(i);
        step();
      end
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = with_last && (i == n - 1);
      bus_noise(i);
      chk("load_ld_ready", ld_ready, 32'd1);
      chk("load_cpu_reset", cpu_reset, 32'd1);
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("load_rdata_zero", rdata, 32'd0);
      chk("load_strobe", out_strobe, 32'd0);
    end
    rw      = 1'b1;
    address = 32'd0;
    if (with_last) begin
      if ((n % 4) == 0) begin
        chk("run_cpu_reset", cpu_reset, 32'd0);
        chk("run_ld_ready", ld_ready, 32'd0);
      end else begin
        chk("flush_ld_ready", ld_ready, 32'd0);
        chk("flush_cpu_reset", cpu_reset, 32'd1);
        step();
        chk("run_cpu_reset", cpu_reset, 32'd0);
        chk("run_ld_ready", ld_ready, 32'd0);
      end
      nw = (n + 3) / 4;
      ref_ovf = (nw >= DEPTH);
    end else begin
      nw = n / 4;
    end
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) w = w | (32'(img[4 * k + j]) << (8 * j));
      end
      ref_mem[k % DEPTH]   = w;
      ref_known[k % DEPTH] = 1'b1;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] got);
    rw      = 1'b1;
    address = a;
    step();
    got = rdata;
    chk("rd_strobe", out_strobe, 32'd0);
  endtask

  task automatic rd_model(input logic [31:0] a);
    logic [31:0] got, v;
    bit known;
    rd(a, got);
    exp_read(a, v, known);
    if (known) chk("rd_model", got, v);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit out_hit;
    rw      = 1'b0;
    address = a;
    wdata   = d;
    out_hit = 1'b0;
    if (a < DEPTH) begin
      ref_mem[a]   = d;
      ref_known[a] = 1'b1;
    end else if (a == IO_BASE) begin
      ref_out = d;
      out_hit = 1'b1;
    end
    step();
    rw = 1'b1;
    chk("wr_strobe", out_strobe, 32'(out_hit));
    chk("wr_out_data", out_data, ref_out);
  endtask

  logic [31:0] got;
  logic [31:0] a;
  logic [31:0] last_word;
  int          n;

  initial begin
    reset    = 1'b1;
    address  = '0;
    wdata    = '0;
    rw       = 1'b1;
    ld_valid = 1'b0;
    ld_byte  = '0;
    ld_last  = 1'b0;
    ref_ovf  = 1'b0;
    ref_out  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end

    // 1: two full words
    apply_reset(3);
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_image(1'b1);
    rd(32'd1, got);
    chk("t1_ram1", got, 32'hDEADBEEF);
    rd(32'd0, got);
    chk("t1_ram0", got, 32'h12345678);

    // 2: partial last word goes through FLUSH
    apply_reset(2);
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    load_image(1'b1);
    rd(32'd1, got);
    chk("t2_ram1", got, 32'h000000AA);
    rd(32'd0, got);
    chk("t2_ram0", got, 32'h04030201);
    rd(IO_BASE + 32'd4, got);
    chk("t2_status", got, 32'h1);

    // 3: RAM write/read, out-of-range access
    wr(32'd3, 32'hCAFEF00D);
    rd(32'd3, got);
    chk("t3_ram3", got, 32'hCAFEF00D);
    rd(DEPTH, got);
    chk("t3_oor_read", got, 32'd0);
    wr(DEPTH, 32'h12341234);
    rd(32'd0, got);
    chk("t3_ram0_kept", got, 32'h04030201);

    // 4: back-to-back OUT_DATA writes
    wr(IO_BASE, 32'h41);
    chk("t4_out1", out_data, 32'h41);
    wr(IO_BASE, 32'h42);
    chk("t4_out2", out_data, 32'h42);
    rd(IO_BASE + 32'd8, got);
    chk("t4_io_other", got, 32'd0);

    // 5: reset mid-word discards the partial, RAM persists
    img = '{8'hA1, 8'hA2};
    apply_reset(1);
    load_image(1'b0);
    apply_reset(3);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_image(1'b1);
    rd(32'd0, got);
    chk("t5_ram0", got, 32'h44332211);
    rd(32'd1, got);
    chk("t5_ram1", got, 32'h000000AA);
    rd_model(32'd3);

    // Random short images
    for (int r = 0; r < 3; r++) begin
      apply_reset(1);
      img = {};
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      load_image(1'b1);
      for (int k = 0; k < (n + 3) / 4; k++) rd_model(32'(k));
      rd_model(IO_BASE + 32'd4);
    end

    // 6: pointer wrap sets overflow
    apply_reset(1);
    img = {};
    for (int i = 0; i < 4 * (DEPTH + 1); i++) img.push_back(8'($urandom));
    last_word = {img[4 * DEPTH + 3], img[4 * DEPTH + 2], img[4 * DEPTH + 1], img[4 * DEPTH]};
    load_image(1'b1);
    rd(32'd0, got);
    chk("t6_ram0_last", got, last_word);
    rd(IO_BASE + 32'd4, got);
    chk("t6_status", got, 32'h3);
    rd_model(32'd1);
    rd_model(32'(DEPTH - 1));

    // Random bus traffic
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 5))
        0, 1: rd_model(32'($urandom_range(0, DEPTH - 1)));
        2:    wr(32'($urandom_range(0, DEPTH - 1)), $urandom);
        3:    rd_model(IO_BASE | 32'($urandom_range(0, 15)));
        4:    wr(IO_BASE | 32'($urandom_range(0, 15)), $urandom);
        default: begin
          a = $urandom_range(32'h0000_0400, 32'h7FFF_FFFF);
          if ($urandom_range(0, 1) == 0) rd_model(a);
          else wr(a, $urandom);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the cpu bus (address, write data, rw, read data).
- Holds a word-addressed program/data RAM and a small memory-mapped I/O window.
- Contains a boot loader FSM that fills RAM from a byte stream while holding the cpu in reset, then releases it.

Parameters:
ADDR_W, 10, RAM index width; depth = 2**ADDR_W words of 32 bits
IO_BASE, 32'hFFFF_FFF0, base of I/O window: +0 OUT_DATA (write), +4 STATUS (read)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
address  in  32  cpu word address
wdata  in  32  cpu write data (cpu datao)
rw  in  1  1 = read, 0 = write
rdata  out  32  read data to cpu (cpu data)
cpu_reset  out  1  active-high hold for cpu; 1 during load
ld_valid  in  1  loader byte valid
ld_byte  in  8  loader byte
ld_last  in  1  marks final byte of image
ld_ready  out  1  loader may present byte
out_data  out  32  last value written to OUT_DATA
out_strobe  out  1  one-cycle pulse per OUT_DATA write

Behaviour:
- Reset (reset=0, async): state=LOAD, cpu_reset=1, ld_ready=1, rdata=0, out_data=0, out_strobe=0, load pointer=0, byte index=0, word count=0. RAM contents are not cleared.
- FSM states are LOAD, FLUSH and RUN.
- LOAD:
  - ld_ready=1.
  - Each clk with ld_valid=1 accepts ld_byte into lane [byte index]. Assembly is little-endian: byte 0 goes to [7:0].
  - The byte index increments mod 4.
  - On the 4th byte, write the assembled word to RAM[load pointer] on the same edge. The load pointer then increments and the assembly register clears.
  - If ld_last accompanies the 4th byte: the word is written and the FSM goes directly to RUN.
  - If ld_last accompanies byte 0-2: the FSM goes to FLUSH, with unfilled upper lanes held at 0.
- FLUSH:
  - ld_ready=0.
  - Writes the zero-padded partial word and increments the pointer.
  - Goes to RUN next cycle.
- Load pointer wrap: if the pointer wraps past 2**ADDR_W-1 it returns to 0 and STATUS.overflow sets.
- RUN:
  - cpu_reset=0 from the first RUN cycle; ld_ready=0; ld_valid is ignored.
  - RUN is left only by reset.
- cpu bus in RUN:
  - Read (rw=1): rdata is registered with 1-cycle latency, i.e. rdata at edge n+1 = mem[address] sampled at edge n.
  - Write (rw=0): RAM[address[ADDR_W-1:0]] <= wdata on the edge.
  - A write followed by a read of the same address on the next cycle returns the new data.
  - Simultaneous read and write of one address is impossible (single rw).
- Address decode:
  - RAM when address < 2**ADDR_W.
  - IO when address[31:4] == IO_BASE[31:4].
  - All other addresses: read returns 0, write is ignored.
- IO:
  - Write to IO_BASE+0 latches out_data=wdata and pulses out_strobe for exactly one cycle.
  - Back-to-back writes give consecutive pulses.
  - Read of IO_BASE+4 returns {30'b0, overflow, run}.
  - Other IO offsets read 0.
- During LOAD/FLUSH: bus writes are ignored and rdata holds 0.
- Reset asserted mid-load discards the partial word. RAM words already written persist.

Decomposition:
- Shared package holds:
  - state encoding (LOAD=0, FLUSH=1, RUN=2, 2 bits)
  - IO offsets (OUT_OFS=0, STATUS_OFS=4)
  - RW_READ=1 / RW_WRITE=0 constants
- One sub-module, mem_ram: single-port 32-bit synchronous RAM with registered read, write enable and index input. The top module muxes the loader and the cpu onto its port.

Test Plan:
1. Load bytes 78,56,34,12,EF,BE,AD,DE with ld_last on the 8th -> RAM[0]=32'h12345678, RAM[1]=32'hDEADBEEF; cpu_reset falls the cycle after the last byte; read address 1 -> rdata=32'hDEADBEEF one cycle later.
2. Load 5 bytes 01,02,03,04,AA with ld_last on AA -> FLUSH visited for one cycle with ld_ready=0; RAM[1]=32'h000000AA; STATUS reads 32'h1.
3. RUN: write 32'hCAFEF00D to address 3, then read address 3 next cycle -> rdata=32'hCAFEF00D; read address 2**ADDR_W -> 0; write there leaves RAM[0] unchanged.
4. RUN: write 32'h41 to IO_BASE, then 32'h42 on the next cycle -> out_strobe high for 2 cycles, out_data 32'h41 then 32'h42; read IO_BASE+8 -> 0.
5. Assert reset after 2 bytes of a word, release, load 4 bytes 11,22,33,44 with ld_last -> RAM[0]=32'h44332211; cpu_reset held 1 throughout the reset.
6. Load 2**ADDR_W+1 words -> RAM[0] holds the last word; STATUS=32'h3.
